// File: rtl/main_fsm_ctrl.sv
// main_fsm_ctrl: multi-cycle instruction sequencer for the PC/IR/ALU/regfile/
// unified-memory datapath. Walks each instruction through its states, drives
// the datapath selects and enables combinationally from the current state,
// stalls on the memory handshake and counts retired instructions.
module main_fsm_ctrl #(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           op,
  input  logic                 mem_ready,
  output logic                 pcupdate,
  output logic                 branch,
  output logic                 regwrite,
  output logic                 memwrite,
  output logic                 irwrite,
  output logic                 adrsrc,
  output logic [1:0]           resultsrc,
  output logic [1:0]           alusrca,
  output logic [1:0]           alusrcb,
  output logic [1:0]           aluop,
  output logic                 illegal_instr,
  output logic [3:0]           state_o,
  output logic [INSTRET_W-1:0] instret
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    JALR     = 4'd11,
    JALRPC   = 4'd12,
    ERROR    = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  state_t                 state_reg;
  state_t                 state_next;
  logic [INSTRET_W-1:0]   instret_reg;
  logic                   retire;

  // An instruction retires whenever the FSM re-enters FETCH from elsewhere.
  assign retire  = (state_next == FETCH) && (state_reg != FETCH);
  assign state_o = state_reg;
  assign instret = instret_reg;

  // State register and retired-instruction counter; reset aborts any
  // in-flight instruction without counting it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= FETCH;
      instret_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (retire) begin
        instret_reg <= instret_reg + INSTRET_W'(1);
      end
    end
  end

  // Next-state selection and per-state datapath controls; everything is
  // forced to 0 while reset is held so no write can slip through.
  always_comb begin
    state_next    = state_reg;
    pcupdate      = 1'b0;
    branch        = 1'b0;
    regwrite      = 1'b0;
    memwrite      = 1'b0;
    irwrite       = 1'b0;
    adrsrc        = 1'b0;
    resultsrc     = 2'b00;
    alusrca       = 2'b00;
    alusrcb       = 2'b00;
    aluop         = 2'b00;
    illegal_instr = 1'b0;

    case (state_reg)
      FETCH: begin
        // PC+4 computed in the ALU and routed straight back to the PC.
        alusrcb   = 2'b10;
        resultsrc = 2'b10;
        irwrite   = mem_ready;
        pcupdate  = mem_ready;
        if (mem_ready) begin
          state_next = DECODE;
        end
      end
      DECODE: begin
        // Speculatively form the branch target into ALUOut.
        alusrca = 2'b01;
        alusrcb = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: state_next = MEMADR;
          OP_RTYPE:          state_next = EXECR;
          OP_ITYPE:          state_next = EXECI;
          OP_BEQ:            state_next = BEQ;
          OP_JAL:            state_next = JAL;
          OP_JALR:           state_next = JALR;
          default:           state_next = ERROR;
        endcase
      end
      MEMADR: begin
        alusrca    = 2'b10;
        alusrcb    = 2'b01;
        state_next = (op == OP_LOAD) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        adrsrc = 1'b1;
        if (mem_ready) begin
          state_next = MEMWB;
        end
      end
      MEMWB: begin
        resultsrc  = 2'b01;
        regwrite   = 1'b1;
        state_next = FETCH;
      end
      MEMWRITE: begin
        // Write strobe held for the whole stall so memory sees it on the ready cycle.
        adrsrc   = 1'b1;
        memwrite = 1'b1;
        if (mem_ready) begin
          state_next = FETCH;
        end
      end
      EXECR: begin
        alusrca    = 2'b10;
        aluop      = 2'b10;
        state_next = ALUWB;
      end
      EXECI: begin
        alusrca    = 2'b10;
        alusrcb    = 2'b01;
        aluop      = 2'b10;
        state_next = ALUWB;
      end
      ALUWB: begin
        regwrite   = 1'b1;
        state_next = FETCH;
      end
      BEQ: begin
        alusrca    = 2'b10;
        aluop      = 2'b01;
        branch     = 1'b1;
        state_next = FETCH;
      end
      JAL: begin
        // PC takes the target already in ALUOut; ALU forms the link OldPC+4.
        alusrca    = 2'b01;
        alusrcb    = 2'b10;
        pcupdate   = 1'b1;
        state_next = ALUWB;
      end
      JALR: begin
        alusrca    = 2'b10;
        alusrcb    = 2'b01;
        state_next = JALRPC;
      end
      JALRPC: begin
        pcupdate   = 1'b1;
        alusrca    = 2'b01;
        alusrcb    = 2'b10;
        state_next = ALUWB;
      end
      ERROR: begin
        // Parked until reset; no enables asserted.
        illegal_instr = 1'b1;
      end
      default: begin
        state_next = ERROR;
      end
    endcase

    if (!rst_n) begin
      pcupdate      = 1'b0;
      branch        = 1'b0;
      regwrite      = 1'b0;
      memwrite      = 1'b0;
      irwrite       = 1'b0;
      adrsrc        = 1'b0;
      resultsrc     = 2'b00;
      alusrca       = 2'b00;
      alusrcb       = 2'b00;
      aluop         = 2'b00;
      illegal_instr = 1'b0;
    end
  end

endmodule
